stream_rx_fifo: RTL and testbench
=================================

# stream_rx_fifo

Receive-side buffer sitting directly downstream of `synchronous_reset_design`. Captures its valid-qualified 16-bit output stream (which has no backpressure) into a small first-word-fall-through FIFO. Presents the words to the next consumer over a valid/ready handshake. Shares that stage's clock, asynchronous reset and synchronous flush so that both stages clear together.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; power of two, minimum 2.
- `DW`, default 16: data width; must match upstream `data_out`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `async_rst_n`  in  1  asynchronous, active-low reset; clears all state immediately.
- `sync_rst`  in  1  synchronous flush, active-high, sampled on rising edge.
- `data_in`  in  DW  word from upstream `data_out`.
- `valid_in`  in  1  from upstream `valid_out`; one word per cycle when high.
- `data_out`  out  DW  head-of-FIFO word.
- `valid_out`  out  1  high when FIFO non-empty.
- `ready_in`  in  1  consumer accepts head word when `valid_out && ready_in` at rising edge.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `level == DEPTH`.
- `overflow`  out  1  sticky; set when a word is dropped.

## Operation
- Storage is a DEPTH-entry register array with `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits each.
  - Both pointers wrap naturally modulo DEPTH.
  - Occupancy is tracked in a separate `level` counter.
- Write: `valid_in` high and the write is allowed.
  - The write is allowed if `!full`, or if `full` and a read happens in the same cycle.
  - `data_in` is stored at `wr_ptr`; `wr_ptr` increments.
- Read: `valid_out && ready_in`. `rd_ptr` increments.
- Level update: increments on write-only, decrements on read-only, and is unchanged on simultaneous write and read.
- Drop: `valid_in` high, `full`, and no read in the same cycle.
  - The word is discarded and `overflow` is set.
  - Pointers and level are unchanged.
- Flush (`sync_rst` high at an edge):
  - Pointers, `level` and `overflow` clear to 0.
  - Flush has priority over a write or read in the same cycle; that cycle's `valid_in` word is discarded and not counted as overflow.
  - Storage array contents are not cleared.
- `async_rst_n` low: same clearing as flush, effective immediately and independent of `clk`. It is asserted any time, including mid-transfer.
- `data_out` is `mem[rd_ptr]`, read combinationally. It is undefined (don't-care) while `valid_out` is low.
- `ready_in` while empty has no effect.

## Timing
- Reset values:
  - `valid_out` = 0, `level` = 0, `full` = 0, `overflow` = 0.
  - `data_out` is don't-care.
- Write latency: a word captured at edge N is on `data_out` with `valid_out` = 1 after edge N. It can be consumed at edge N+1.
- Throughput: one write and one read per cycle, sustained. A full FIFO stays full with zero drops if `ready_in` is held high.
- `valid_out`, `full` and `level` are derived from registered state only. There is no combinational path from `valid_in` or `ready_in` to them.
- `valid_out` depends on nothing but the registered level. It does not depend on `ready_in`.

## Configuration
- Macro `STREAM_RX_FIFO_DROP_CNT_EN`.
- Defined: adds output `drop_count` (16 bits).
  - Increments on each dropped word and saturates at 16'hFFFF.
  - Cleared by `async_rst_n` and by `sync_rst`; reset value 0.
- Undefined: the `drop_count` port and its counter are absent. Only sticky `overflow` reports drops.

## Test plan
All scenarios use DEPTH=4.
- Fill and drain:
  - Write 16'h1001..16'h1004 with `ready_in`=0 → `level`=4 and `full`=1.
  - Then `ready_in`=1 → `data_out` yields 16'h1001..16'h1004 in order and `level` returns to 0.
- Overflow:
  - Fill with 16'h2001..16'h2004 (`ready_in`=0), then write 16'h2005 → `overflow`=1 and `level`=4.
  - Then drain → 16'h2005 never appears.
  - With the macro defined, `drop_count`=1.
- Simultaneous full write and read:
  - With the FIFO full of 16'h3001..16'h3004, set `valid_in`=1 with 16'h3005 and `ready_in`=1 for one cycle → no overflow and `level` stays 4.
  - Drain → 16'h3002..16'h3005.
- Flush priority:
  - FIFO holds 16'h4001..16'h4003; assert `sync_rst` and `valid_in` (16'h4004) in the same cycle → next cycle `level`=0, `valid_out`=0 and `overflow`=0.
  - A subsequent write of 16'h4005 is the first word out.
- Async reset mid-operation:
  - During streaming, drop `async_rst_n` 3 ns after a rising edge for 10 ns → `valid_out`, `level` and `overflow` are 0 before the next edge.
  - After release, writing 16'h5001 gives `data_out`=16'h5001 one cycle later.
- Pointer wrap: stream 16'h6001..16'h600A with `ready_in`=1 continuously → each word is output one cycle after entry, with no loss, through two pointer wraps.

Source files
------------

// File: rtl/stream_rx_fifo.sv
// Receive-side first-word-fall-through FIFO behind a no-backpressure valid stream.
// Optional STREAM_RX_FIFO_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module stream_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     async_rst_n,
    input  logic                     sync_rst,
    input  logic [DW-1:0]            data_in,
    input  logic                     valid_in,
    output logic [DW-1:0]            data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
`ifdef STREAM_RX_FIFO_DROP_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic          rd_en;
    logic          wr_en;
    logic          drop;

    // Status comes only from the registered level, never from valid_in/ready_in.
    assign valid_out = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign data_out  = mem[rd_ptr];

    always_comb begin
        rd_en = valid_out && ready_in && !sync_rst;
        wr_en = valid_in && !sync_rst && (!full || rd_en);
        drop  = valid_in && !sync_rst && full && !rd_en;
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (sync_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                level_q <= level_q + LW'(1);
            end else if (rd_en && !wr_en) begin
                level_q <= level_q - LW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef STREAM_RX_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            drop_count <= '0;
        end else if (sync_rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_rx_fifo.sv
// Scoreboard bench for stream_rx_fifo (DEPTH=4): stimulus queues expected words,
// a negedge monitor pops and compares every accepted head word.
module tb_stream_rx_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          async_rst_n;
    logic          sync_rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic [2:0]    level;
    logic          full;
    logic          overflow;
`ifdef STREAM_RX_FIFO_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    stream_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .sync_rst    (sync_rst),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .level       (level),
        .full        (full),
`ifdef STREAM_RX_FIFO_DROP_CNT_EN
        .drop_count  (drop_count),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a head word with valid_out && ready_in at negedge is consumed at the next edge.
    always @(negedge clk) begin
        if (async_rst_n === 1'b1 && sync_rst === 1'b0 && valid_out === 1'b1 && ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected none", data_out);
            end else begin
                check("data_out", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] w, input bit accept);
        valid_in = 1'b1;
        data_in  = w;
        if (accept) exp_q.push_back(w);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        ready_in = 1'b1;
        n = 0;
        while (level != 0 && n < 20) begin
            tick();
            n++;
        end
        ready_in = 1'b0;
        check({name, "_drain_level"}, {29'h0, level}, 32'd0);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        async_rst_n = 1'b0;
        sync_rst    = 1'b0;
        valid_in    = 1'b0;
        ready_in    = 1'b0;
        data_in     = '0;
        #1;
        check("rst_valid_out", {31'h0, valid_out}, 32'd0);
        check("rst_level", {29'h0, level}, 32'd0);
        check("rst_full", {31'h0, full}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
`ifdef STREAM_RX_FIFO_DROP_CNT_EN
        check("rst_drop_count", {16'h0, drop_count}, 32'd0);
`endif
        #21 async_rst_n = 1'b1;
        tick();

        // Fill and drain
        for (int i = 1; i <= 4; i++) wr(16'h1000 + 16'(i), 1'b1);
        check("fill_level", {29'h0, level}, 32'd4);
        check("fill_full", {31'h0, full}, 32'd1);
        check("fill_head", {16'h0, data_out}, 32'h1001);
        drain("fill");
        check("drained_valid", {31'h0, valid_out}, 32'd0);

        // Overflow
        for (int i = 1; i <= 4; i++) wr(16'h2000 + 16'(i), 1'b1);
        wr(16'h2005, 1'b0);
        check("ovf_flag", {31'h0, overflow}, 32'd1);
        check("ovf_level", {29'h0, level}, 32'd4);
`ifdef STREAM_RX_FIFO_DROP_CNT_EN
        check("ovf_drop_count", {16'h0, drop_count}, 32'd1);
`endif
        drain("ovf");
        check("ovf_sticky", {31'h0, overflow}, 32'd1);
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        check("flush_clears_ovf", {31'h0, overflow}, 32'd0);

        // Simultaneous write and read while full
        for (int i = 1; i <= 4; i++) wr(16'h3000 + 16'(i), 1'b1);
        ready_in = 1'b1;
        wr(16'h3005, 1'b1);
        ready_in = 1'b0;
        check("simul_ovf", {31'h0, overflow}, 32'd0);
        check("simul_level", {29'h0, level}, 32'd4);
        drain("simul");

        // Flush priority over a same-cycle write
        for (int i = 1; i <= 3; i++) wr(16'h4000 + 16'(i), 1'b1);
        exp_q.delete();
        sync_rst = 1'b1;
        wr(16'h4004, 1'b0);
        sync_rst = 1'b0;
        check("flush_level", {29'h0, level}, 32'd0);
        check("flush_valid", {31'h0, valid_out}, 32'd0);
        check("flush_ovf", {31'h0, overflow}, 32'd0);
        wr(16'h4005, 1'b1);
        check("flush_first", {16'h0, data_out}, 32'h4005);
        drain("flush");

        // Async reset mid-stream, with overflow set beforehand
        for (int i = 1; i <= 4; i++) wr(16'h50F0 + 16'(i), 1'b1);
        wr(16'h50FF, 1'b0);
        ready_in = 1'b1;
        for (int i = 1; i <= 3; i++) wr(16'h50A0 + 16'(i), 1'b1);
        #2 async_rst_n = 1'b0;
        ready_in = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", {31'h0, valid_out}, 32'd0);
        check("arst_level", {29'h0, level}, 32'd0);
        check("arst_ovf", {31'h0, overflow}, 32'd0);
        check("arst_full", {31'h0, full}, 32'd0);
        #9 async_rst_n = 1'b1;
        tick();
        wr(16'h5001, 1'b1);
        check("arst_after_data", {16'h0, data_out}, 32'h5001);
        check("arst_after_valid", {31'h0, valid_out}, 32'd1);
        drain("arst");

        // Pointer wrap under continuous streaming
        ready_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wr(16'h6000 + 16'(i), 1'b1);
            check("wrap_level", {29'h0, level}, 32'd1);
            check("wrap_head", {16'h0, data_out}, {16'h0, 16'h6000 + 16'(i)});
        end
        tick();
        ready_in = 1'b0;
        check("wrap_end_level", {29'h0, level}, 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
